// File: rtl/mouse_pkg.sv
// Register map, mode/status bit positions and position arithmetic helpers
// shared by the mouse PIA and its per-axis datapath.
package mouse_pkg;
  localparam int unsigned AW = 17;

  localparam logic [3:0] OFS_XLO     = 4'h0;
  localparam logic [3:0] OFS_XHI     = 4'h1;
  localparam logic [3:0] OFS_YLO     = 4'h2;
  localparam logic [3:0] OFS_YHI     = 4'h3;
  localparam logic [3:0] OFS_STATUS  = 4'h4;
  localparam logic [3:0] OFS_MODE    = 4'h5;
  localparam logic [3:0] OFS_CMIN_LO = 4'h6;
  localparam logic [3:0] OFS_CMIN_HI = 4'h7;
  localparam logic [3:0] OFS_CMAX_LO = 4'h8;
  localparam logic [3:0] OFS_CMAX_HI = 4'h9;
  localparam logic [3:0] OFS_COMMIT  = 4'hA;
  localparam logic [3:0] OFS_CLR_IRQ = 4'hB;

  localparam int unsigned MODE_EN      = 0;
  localparam int unsigned MODE_MOVE_IE = 1;
  localparam int unsigned MODE_BTN_IE  = 2;
  localparam int unsigned MODE_VBL_IE  = 3;

  localparam int unsigned ST_BTN_NOW  = 7;
  localparam int unsigned ST_BTN_LAST = 6;
  localparam int unsigned ST_MOVED    = 5;
  localparam int unsigned ST_IRQ_VBL  = 3;
  localparam int unsigned ST_IRQ_MOVE = 2;
  localparam int unsigned ST_IRQ_BTN  = 1;

  typedef struct packed {
    logic [7:0] dy;
    logic [7:0] dx;
    logic       sy;
    logic       sx;
    logic       btn;
  } pkt_t;

  function automatic logic [AW-1:0] sext9(input logic [8:0] d);
    return {{(AW-9){d[8]}}, d};
  endfunction

  function automatic logic [15:0] sat_clamp(input logic [AW-1:0] v,
                                            input logic [15:0]   lo,
                                            input logic [15:0]   hi);
    logic signed [AW-1:0] sv, slo, shi;
    sv  = v;
    slo = {{(AW-16){lo[15]}}, lo};
    shi = {{(AW-16){hi[15]}}, hi};
    if (sv > shi)      return hi;
    else if (sv < slo) return lo;
    return v[15:0];
  endfunction
endpackage

// File: rtl/mouse_axis.sv
// One mouse axis: 16-bit signed position, saturating delta add and
// committed clamp window with a deferred re-clamp after each commit.
module mouse_axis
  import mouse_pkg::*;
#(
  parameter logic [15:0] MIN_RST = 16'h0000,
  parameter logic [15:0] MAX_RST = 16'h03FF
)(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_lo,
  input  logic          i_wr_hi,
  input  logic [7:0]    i_wdata,
  input  logic          i_apply,
  input  logic [AW-1:0] i_delta,
  input  logic          i_commit,
  input  logic [15:0]   i_min,
  input  logic [15:0]   i_max,
  output logic [15:0]   o_pos
);
  logic [15:0]   r_pos, r_min, r_max;
  logic          r_reclamp;
  logic [AW-1:0] w_sum;

  assign w_sum = {{(AW-16){r_pos[15]}}, r_pos} + (i_apply ? i_delta : '0);

  // A packet landing on the re-clamp cycle is folded into the same clamp.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pos     <= '0;
      r_min     <= MIN_RST;
      r_max     <= MAX_RST;
      r_reclamp <= 1'b0;
    end else begin
      r_reclamp <= i_commit;
      if (i_commit) begin
        r_min <= i_min;
        r_max <= i_max;
      end
      if (i_wr_lo)                    r_pos[7:0]  <= i_wdata;
      else if (i_wr_hi)               r_pos[15:8] <= i_wdata;
      else if (i_apply || r_reclamp)  r_pos       <= sat_clamp(w_sum, r_min, r_max);
    end
  end

  assign o_pos = r_pos;
endmodule

// File: rtl/mouse_pia.sv
// Mouse card PIA: host register file, PS/2 packet ingest into two clamped
// axes, status/mode registers and VBL/move/button interrupts.
module mouse_pia
  import mouse_pkg::*;
#(
  parameter int CLAMP_MAX_DEFAULT = 1023,
  parameter int CLAMP_MIN_DEFAULT = 0
)(
  input  logic        CLK_14M,
  input  logic        RESET,
  input  logic        DEVICE_SELECT_N,
  input  logic [15:0] ADDRESS,
  input  logic        RW_N,
  input  logic [7:0]  DATA_IN,
  input  logic [24:0] PS2_MOUSE,
  input  logic        VBL,
  output logic [7:0]  DATA_OUT,
  output logic        IRQ_N
);
  localparam logic [15:0] MIN_RST = 16'(CLAMP_MIN_DEFAULT);
  localparam logic [15:0] MAX_RST = 16'(CLAMP_MAX_DEFAULT);

  logic        r_sel_d, r_tog, r_vbl_d, r_pend_v;
  logic [3:0]  r_mode;
  logic [15:0] r_cmin, r_cmax;
  logic        r_btn_now, r_btn_last, r_moved;
  logic        r_irq_vbl, r_irq_move, r_irq_btn, r_irq_n;
  pkt_t        r_pend;

  logic [3:0]    w_ofs;
  logic          w_access, w_wr, w_st_rd, w_clr_irq, w_hold;
  logic          w_commit_x, w_commit_y, w_new_pkt, w_apply, w_nz;
  logic          w_set_move, w_set_btn, w_set_vbl;
  pkt_t          w_in_pkt, w_pkt;
  logic [AW-1:0] w_dx, w_dy;
  logic [15:0]   w_xpos, w_ypos;
  logic [7:0]    w_status;
  logic          w_unused;

  assign w_ofs      = ADDRESS[3:0];
  assign w_access   = r_sel_d & ~DEVICE_SELECT_N;
  assign w_wr       = w_access & ~RW_N;
  assign w_st_rd    = w_access & RW_N & (w_ofs == OFS_STATUS);
  assign w_clr_irq  = w_wr & (w_ofs == OFS_CLR_IRQ);
  assign w_commit_x = w_wr & (w_ofs == OFS_COMMIT) & ~DATA_IN[0];
  assign w_commit_y = w_wr & (w_ofs == OFS_COMMIT) & DATA_IN[0];
  assign w_hold     = w_wr & ((w_ofs <= OFS_YHI) | (w_ofs == OFS_COMMIT));

  assign w_in_pkt  = '{dy: PS2_MOUSE[23:16], dx: PS2_MOUSE[15:8],
                       sy: PS2_MOUSE[5], sx: PS2_MOUSE[4], btn: PS2_MOUSE[0]};
  assign w_new_pkt = (PS2_MOUSE[24] ^ r_tog) & r_mode[MODE_EN];

  // Host position writes win; a colliding packet waits one cycle in r_pend.
  always_comb begin
    w_apply = 1'b0;
    w_pkt   = w_in_pkt;
    if (!w_hold) begin
      if (r_pend_v) begin
        w_apply = 1'b1;
        w_pkt   = r_pend;
      end else begin
        w_apply = w_new_pkt;
      end
    end
  end

  assign w_dx       = sext9({w_pkt.sx, w_pkt.dx});
  assign w_dy       = '0 - sext9({w_pkt.sy, w_pkt.dy});
  assign w_nz       = |{w_pkt.sx, w_pkt.dx, w_pkt.sy, w_pkt.dy};
  assign w_set_move = w_apply & w_nz;
  assign w_set_btn  = w_apply & (w_pkt.btn != r_btn_now) & r_mode[MODE_BTN_IE];
  assign w_set_vbl  = VBL & ~r_vbl_d & r_mode[MODE_VBL_IE] & r_mode[MODE_EN];

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      r_sel_d    <= 1'b0;
      r_tog      <= PS2_MOUSE[24];
      r_vbl_d    <= VBL;
      r_pend_v   <= 1'b0;
      r_pend     <= '0;
      r_mode     <= '0;
      r_cmin     <= MIN_RST;
      r_cmax     <= MAX_RST;
      r_btn_now  <= 1'b0;
      r_btn_last <= 1'b0;
      r_moved    <= 1'b0;
      r_irq_vbl  <= 1'b0;
      r_irq_move <= 1'b0;
      r_irq_btn  <= 1'b0;
      r_irq_n    <= 1'b1;
    end else begin
      r_sel_d <= DEVICE_SELECT_N;
      r_tog   <= PS2_MOUSE[24];
      r_vbl_d <= VBL;
      if (w_hold) begin
        if (w_new_pkt) begin
          r_pend_v <= 1'b1;
          r_pend   <= w_in_pkt;
        end
      end else begin
        r_pend_v <= r_pend_v & w_new_pkt;
        if (w_new_pkt) r_pend <= w_in_pkt;
      end
      if (w_wr) begin
        case (w_ofs)
          OFS_MODE:    r_mode        <= DATA_IN[3:0];
          OFS_CMIN_LO: r_cmin[7:0]   <= DATA_IN;
          OFS_CMIN_HI: r_cmin[15:8]  <= DATA_IN;
          OFS_CMAX_LO: r_cmax[7:0]   <= DATA_IN;
          OFS_CMAX_HI: r_cmax[15:8]  <= DATA_IN;
          default: ;
        endcase
      end
      if (w_apply) r_btn_now  <= w_pkt.btn;
      if (w_st_rd) r_btn_last <= r_btn_now;
      r_moved    <= (r_moved & ~w_st_rd) | w_set_move;
      r_irq_move <= (r_irq_move & ~w_clr_irq) | (w_set_move & r_mode[MODE_MOVE_IE]);
      r_irq_btn  <= (r_irq_btn & ~w_clr_irq) | w_set_btn;
      r_irq_vbl  <= (r_irq_vbl & ~w_clr_irq) | w_set_vbl;
      r_irq_n    <= ~(r_irq_vbl | r_irq_move | r_irq_btn);
    end
  end

  mouse_axis #(.MIN_RST(MIN_RST), .MAX_RST(MAX_RST)) u_axis_x (
    .i_clk    (CLK_14M),
    .i_reset  (RESET),
    .i_wr_lo  (w_wr & (w_ofs == OFS_XLO)),
    .i_wr_hi  (w_wr & (w_ofs == OFS_XHI)),
    .i_wdata  (DATA_IN),
    .i_apply  (w_apply),
    .i_delta  (w_dx),
    .i_commit (w_commit_x),
    .i_min    (r_cmin),
    .i_max    (r_cmax),
    .o_pos    (w_xpos)
  );

  mouse_axis #(.MIN_RST(MIN_RST), .MAX_RST(MAX_RST)) u_axis_y (
    .i_clk    (CLK_14M),
    .i_reset  (RESET),
    .i_wr_lo  (w_wr & (w_ofs == OFS_YLO)),
    .i_wr_hi  (w_wr & (w_ofs == OFS_YHI)),
    .i_wdata  (DATA_IN),
    .i_apply  (w_apply),
    .i_delta  (w_dy),
    .i_commit (w_commit_y),
    .i_min    (r_cmin),
    .i_max    (r_cmax),
    .o_pos    (w_ypos)
  );

  always_comb begin
    w_status              = '0;
    w_status[ST_BTN_NOW]  = r_btn_now;
    w_status[ST_BTN_LAST] = r_btn_last;
    w_status[ST_MOVED]    = r_moved;
    w_status[ST_IRQ_VBL]  = r_irq_vbl;
    w_status[ST_IRQ_MOVE] = r_irq_move;
    w_status[ST_IRQ_BTN]  = r_irq_btn;
  end

  always_comb begin
    DATA_OUT = '0;
    case (w_ofs)
      OFS_XLO:     DATA_OUT = w_xpos[7:0];
      OFS_XHI:     DATA_OUT = w_xpos[15:8];
      OFS_YLO:     DATA_OUT = w_ypos[7:0];
      OFS_YHI:     DATA_OUT = w_ypos[15:8];
      OFS_STATUS:  DATA_OUT = w_status;
      OFS_MODE:    DATA_OUT = {4'b0000, r_mode};
      OFS_CMIN_LO: DATA_OUT = r_cmin[7:0];
      OFS_CMIN_HI: DATA_OUT = r_cmin[15:8];
      OFS_CMAX_LO: DATA_OUT = r_cmax[7:0];
      OFS_CMAX_HI: DATA_OUT = r_cmax[15:8];
      default:     DATA_OUT = '0;
    endcase
  end

  assign IRQ_N    = r_irq_n;
  assign w_unused = ^{ADDRESS[15:4], PS2_MOUSE[7:6], PS2_MOUSE[3:1]};
endmodule

// File: tb/tb_mouse_pia.sv
// Scoreboard bench for mouse_pia: stimulus queues expected read data / IRQ_N
// levels, a monitor pops and compares on each sample request.
module tb_mouse_pia;
  logic        CLK_14M = 1'b0;
  logic        RESET = 1'b1;
  logic        DEVICE_SELECT_N = 1'b1;
  logic [15:0] ADDRESS = '0;
  logic        RW_N = 1'b1;
  logic [7:0]  DATA_IN = '0;
  logic [24:0] PS2_MOUSE = '0;
  logic        VBL = 1'b0;
  logic [7:0]  DATA_OUT;
  logic        IRQ_N;

  logic        chk_req = 1'b0;
  logic [8:0]  q_exp[$];
  string       q_name[$];
  int          checks = 0;
  int          errors = 0;

  mouse_pia #(.CLAMP_MAX_DEFAULT(1023), .CLAMP_MIN_DEFAULT(0)) dut (
    .CLK_14M         (CLK_14M),
    .RESET           (RESET),
    .DEVICE_SELECT_N (DEVICE_SELECT_N),
    .ADDRESS         (ADDRESS),
    .RW_N            (RW_N),
    .DATA_IN         (DATA_IN),
    .PS2_MOUSE       (PS2_MOUSE),
    .VBL             (VBL),
    .DATA_OUT        (DATA_OUT),
    .IRQ_N           (IRQ_N)
  );

  always #5 CLK_14M = ~CLK_14M;

  // Monitor: bit8 of the queued entry selects IRQ_N (1) or DATA_OUT (0).
  always @(negedge CLK_14M) begin : monitor
    logic [8:0] e;
    logic [7:0] act;
    string      n;
    if (chk_req) begin
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got sample request, required a queued entry");
      end else begin
        e   = q_exp.pop_front();
        n   = q_name.pop_front();
        act = e[8] ? {7'b0, IRQ_N} : DATA_OUT;
        if (act !== e[7:0]) begin
          errors++;
          $display("FAIL %s: got 0x%02h required 0x%02h", n, act, e[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK_14M);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] ofs, input logic [7:0] d);
    step();
    ADDRESS = {12'h000, ofs}; RW_N = 1'b0; DATA_IN = d; DEVICE_SELECT_N = 1'b0;
    step();
    DEVICE_SELECT_N = 1'b1; RW_N = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] ofs, input logic [7:0] expv, input string name);
    step();
    ADDRESS = {12'h000, ofs}; RW_N = 1'b1; DEVICE_SELECT_N = 1'b0;
    q_exp.push_back({1'b0, expv}); q_name.push_back(name); chk_req = 1'b1;
    step();
    DEVICE_SELECT_N = 1'b1; chk_req = 1'b0;
  endtask

  task automatic chk_irq(input logic expv, input string name);
    step();
    q_exp.push_back({1'b1, 7'b0, expv}); q_name.push_back(name); chk_req = 1'b1;
    step();
    chk_req = 1'b0;
  endtask

  task automatic pkt_bits(input logic [7:0] dx, input logic sx,
                          input logic [7:0] dy, input logic sy, input logic btn);
    PS2_MOUSE = {~PS2_MOUSE[24], dy, dx, 2'b00, sy, sx, 3'b000, btn};
  endtask

  task automatic packet(input logic [7:0] dx, input logic sx,
                        input logic [7:0] dy, input logic sy, input logic btn);
    step();
    pkt_bits(dx, sx, dy, sy, btn);
    step();
    step();
  endtask

  initial begin
    repeat (3) step();
    RESET = 1'b0;
    step();

    // reset state
    bus_rd(4'h0, 8'h00, "rst_xlo");
    bus_rd(4'h1, 8'h00, "rst_xhi");
    bus_rd(4'h2, 8'h00, "rst_ylo");
    bus_rd(4'h4, 8'h00, "rst_status");
    bus_rd(4'h5, 8'h00, "rst_mode");
    bus_rd(4'h6, 8'h00, "rst_cmin_lo");
    bus_rd(4'h8, 8'hFF, "rst_cmax_lo");
    bus_rd(4'h9, 8'h03, "rst_cmax_hi");
    bus_rd(4'hC, 8'h00, "undef_ofs");
    chk_irq(1'b1, "rst_irq_n");

    // enable, dX=+5, moved set then cleared by the status read
    bus_wr(4'h5, 8'h01);
    packet(8'h05, 1'b0, 8'h00, 1'b0, 1'b0);
    bus_rd(4'h0, 8'h05, "x_plus5_lo");
    bus_rd(4'h1, 8'h00, "x_plus5_hi");
    bus_rd(4'h4, 8'h20, "status_moved");
    bus_rd(4'h4, 8'h00, "status_moved_cleared");

    // clamp at max and at min
    bus_wr(4'h0, 8'hFC);
    bus_wr(4'h1, 8'h03);
    packet(8'h0A, 1'b0, 8'h00, 1'b0, 1'b0);
    bus_rd(4'h0, 8'hFF, "x_clamp_max_lo");
    bus_rd(4'h1, 8'h03, "x_clamp_max_hi");
    bus_wr(4'h0, 8'h03);
    bus_wr(4'h1, 8'h00);
    packet(8'hF6, 1'b1, 8'h00, 1'b0, 1'b0);
    bus_rd(4'h0, 8'h00, "x_clamp_min_lo");
    bus_rd(4'h1, 8'h00, "x_clamp_min_hi");

    // Y is inverted: dY=+3 decrements, then saturates at 0
    bus_wr(4'h2, 8'h05);
    packet(8'h00, 1'b0, 8'h03, 1'b0, 1'b0);
    bus_rd(4'h2, 8'h02, "y_minus3");
    packet(8'h00, 1'b0, 8'h03, 1'b0, 1'b0);
    bus_rd(4'h2, 8'h00, "y_sat_lo");
    bus_rd(4'h3, 8'h00, "y_sat_hi");
    bus_rd(4'h4, 8'h20, "status_after_moves");

    // button change with button IRQ enabled
    bus_wr(4'h5, 8'h05);
    packet(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_irq(1'b0, "btn_irq_low");
    bus_rd(4'h4, 8'h82, "status_btn_irq");
    bus_rd(4'h4, 8'hC2, "status_btn_last");
    bus_wr(4'hB, 8'h00);
    chk_irq(1'b1, "btn_irq_cleared");
    bus_rd(4'h4, 8'hC0, "status_flags_cleared");

    // VBL interrupt, registered one cycle behind the flag
    bus_wr(4'h5, 8'h09);
    step();
    VBL = 1'b1;
    chk_irq(1'b1, "vbl_irq_lag");
    chk_irq(1'b0, "vbl_irq_low");
    bus_rd(4'h4, 8'hC8, "status_vbl");
    bus_wr(4'hB, 8'h00);
    chk_irq(1'b1, "vbl_irq_cleared");
    VBL = 1'b0;

    // host X write collides with packet dX=+1
    bus_wr(4'h5, 8'h01);
    step();
    ADDRESS = 16'h0000; RW_N = 1'b0; DATA_IN = 8'h40; DEVICE_SELECT_N = 1'b0;
    pkt_bits(8'h01, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    DEVICE_SELECT_N = 1'b1; RW_N = 1'b1;
    step();
    bus_rd(4'h0, 8'h41, "collide_x_lo");
    bus_rd(4'h1, 8'h00, "collide_x_hi");

    // commit clamp window [0x10,0x20] to X
    bus_wr(4'h6, 8'h10);
    bus_wr(4'h7, 8'h00);
    bus_wr(4'h8, 8'h20);
    bus_wr(4'h9, 8'h00);
    bus_wr(4'h0, 8'h05);
    bus_wr(4'hA, 8'h00);
    bus_rd(4'h0, 8'h10, "commit_x_reclamp");
    bus_rd(4'h8, 8'h20, "stage_cmax_lo");
    packet(8'h30, 1'b0, 8'h00, 1'b0, 1'b1);
    bus_rd(4'h0, 8'h20, "commit_x_new_max");
    bus_rd(4'h2, 8'h00, "y_untouched");

    // reset mid-packet and mid-access
    step();
    RESET = 1'b1;
    pkt_bits(8'h05, 1'b0, 8'h00, 1'b0, 1'b1);
    ADDRESS = 16'h0005; RW_N = 1'b0; DATA_IN = 8'h0F; DEVICE_SELECT_N = 1'b0;
    step();
    step();
    RESET = 1'b0;
    step();
    step();
    DEVICE_SELECT_N = 1'b1; RW_N = 1'b1;
    bus_rd(4'h0, 8'h00, "rst2_xlo");
    bus_rd(4'h2, 8'h00, "rst2_ylo");
    bus_rd(4'h4, 8'h00, "rst2_status");
    bus_rd(4'h5, 8'h00, "rst2_mode");
    bus_rd(4'h6, 8'h00, "rst2_cmin_lo");
    bus_rd(4'h8, 8'hFF, "rst2_cmax_lo");
    bus_rd(4'h9, 8'h03, "rst2_cmax_hi");
    chk_irq(1'b1, "rst2_irq_n");

    for (int i = 0; i < 100 && q_exp.size() != 0; i++) step();
    if (q_exp.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
